// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage: arbitrates flush, branch and
// sequential sources, honours the stall bus and holds a branch taken during a stall.
module pc_gen #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = 32'hBFC0_0000,
  parameter int                STEP_LOG2 = 2,
  parameter int                KEEP_MSB  = 1,
  parameter int                STALL_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] ctrl_stall,
  input  logic               be,
  input  logic [ADDR_W-1:0]  baddr,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  flush_addr,
  output logic [ADDR_W-1:0]  pc,
  output logic               ce,
  output logic               redirect_pending,
  output logic               misalign
);

  localparam logic [ADDR_W-1:0] STEP = {{(ADDR_W-1){1'b0}}, 1'b1} << STEP_LOG2;

  logic              ce_r;
  logic [ADDR_W-1:0] pc_r;
  logic              pending_r;
  logic [ADDR_W-1:0] stored_r;

  logic [ADDR_W-1:0] pc_next_s;
  logic              pending_next_s;
  logic [ADDR_W-1:0] stored_next_s;
  logic [ADDR_W-1:0] seq_s;
  logic [ADDR_W-2:0] inc_low_s;
  logic              unused_stall_s;

  // Only bit 0 of the stall bus holds this stage.
  assign unused_stall_s = ^ctrl_stall;

  // Sequential successor; with KEEP_MSB the top bit (segment select) never toggles.
  assign inc_low_s = pc_r[ADDR_W-2:0] + STEP[ADDR_W-2:0];
  assign seq_s     = (KEEP_MSB != 0) ? {pc_r[ADDR_W-1], inc_low_s} : (pc_r + STEP);

  // Next-state arbitration: flush > stall (capture branch) > live branch > stored branch > sequential.
  always_comb begin
    pc_next_s      = pc_r;
    pending_next_s = pending_r;
    stored_next_s  = stored_r;
    if (!ce_r) begin
      pc_next_s = RESET_VEC;
    end else if (flush) begin
      pc_next_s      = flush_addr;
      pending_next_s = 1'b0;
    end else if (ctrl_stall[0]) begin
      if (be) begin
        stored_next_s  = baddr;
        pending_next_s = 1'b1;
      end else begin
        stored_next_s  = stored_r;
      end
    end else if (be) begin
      pc_next_s      = baddr;
      pending_next_s = 1'b0;
    end else if (pending_r) begin
      pc_next_s      = stored_r;
      pending_next_s = 1'b0;
    end else begin
      pc_next_s = seq_s;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_r      <= 1'b0;
      pc_r      <= RESET_VEC;
      pending_r <= 1'b0;
      stored_r  <= {ADDR_W{1'b0}};
    end else begin
      ce_r      <= 1'b1;
      pc_r      <= pc_next_s;
      pending_r <= pending_next_s;
      stored_r  <= stored_next_s;
    end
  end

  assign pc               = pc_r;
  assign ce               = ce_r;
  assign redirect_pending = pending_r;

  generate
    if (STEP_LOG2 == 0) begin : g_no_align
      assign misalign = 1'b0;
    end else begin : g_align
      assign misalign = ce_r && (pc_r[STEP_LOG2-1:0] != {STEP_LOG2{1'b0}});
    end
  endgenerate

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: expected pc/ce/pending pushed per driven cycle,
// popped and compared one edge later; wrap variants checked alongside.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  ctrl_stall;
  logic        be;
  logic [31:0] baddr;
  logic [31:0] baddr_s0;
  logic        flush;
  logic [31:0] flush_addr;

  logic [31:0] pc, pc_nk, pc_s0;
  logic        ce, ce_nk, ce_s0;
  logic        pend, pend_nk, pend_s0;
  logic        mis, mis_nk, mis_s0;

  typedef struct packed {
    logic [31:0] pc;
    logic        ce;
    logic        pend;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk(clk), .rst(rst), .ctrl_stall(ctrl_stall), .be(be), .baddr(baddr),
    .flush(flush), .flush_addr(flush_addr), .pc(pc), .ce(ce),
    .redirect_pending(pend), .misalign(mis)
  );

  pc_gen #(.KEEP_MSB(0)) dut_nk (
    .clk(clk), .rst(rst), .ctrl_stall(ctrl_stall), .be(be), .baddr(baddr),
    .flush(flush), .flush_addr(flush_addr), .pc(pc_nk), .ce(ce_nk),
    .redirect_pending(pend_nk), .misalign(mis_nk)
  );

  pc_gen #(.STEP_LOG2(0)) dut_s0 (
    .clk(clk), .rst(rst), .ctrl_stall(ctrl_stall), .be(be), .baddr(baddr_s0),
    .flush(flush), .flush_addr(flush_addr), .pc(pc_s0), .ce(ce_s0),
    .redirect_pending(pend_s0), .misalign(mis_s0)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic cyc(input logic st, input logic b, input logic [31:0] ba,
                     input logic f, input logic [31:0] fa,
                     input logic [31:0] epc, input logic ece, input logic epend,
                     input string tag);
    exp_t e;
    ctrl_stall = {5'b00000, st};
    be         = b;
    baddr      = ba;
    flush      = f;
    flush_addr = fa;
    exp_q.push_back('{pc: epc, ce: ece, pend: epend});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq({tag, ".pc"},   pc,   e.pc);
    check_eq({tag, ".ce"},   {31'd0, ce},   {31'd0, e.ce});
    check_eq({tag, ".pend"}, {31'd0, pend}, {31'd0, e.pend});
    check_eq({tag, ".mis"},  {31'd0, mis},
             {31'd0, (e.ce && (e.pc[1:0] != 2'b00))});
    ctrl_stall = 6'd0;
    be         = 1'b0;
    flush      = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    ctrl_stall = 6'd0;
    be         = 1'b0;
    baddr      = 32'h0000_0000;
    baddr_s0   = 32'hFFFF_FFFF;
    flush      = 1'b0;
    flush_addr = 32'h0000_0000;

    #12;
    check_eq("rst.pc",   pc, 32'hBFC0_0000);
    check_eq("rst.ce",   {31'd0, ce},   32'd0);
    check_eq("rst.pend", {31'd0, pend}, 32'd0);
    check_eq("rst.mis",  {31'd0, mis},  32'd0);

    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'hBFC0_0000, 1'b1, 1'b0, "e1");
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'hBFC0_0004, 1'b1, 1'b0, "e2");
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'hBFC0_0008, 1'b1, 1'b0, "e3");

    // Wrap-around across the three parameter variants.
    cyc(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'hFFFF_FFFC, 1'b1, 1'b0, "wbr");
    check_eq("wbr.nk", pc_nk, 32'hFFFF_FFFC);
    check_eq("wbr.s0", pc_s0, 32'hFFFF_FFFF);
    check_eq("wbr.s0mis", {31'd0, mis_s0}, 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h8000_0000, 1'b1, 1'b0, "wrap");
    check_eq("wrap.nk", pc_nk, 32'h0000_0000);
    check_eq("wrap.s0", pc_s0, 32'h8000_0000);

    cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hBFC0_0000, 32'hBFC0_0000, 1'b1, 1'b0, "fl0");

    // Branch captured during a three-cycle stall.
    cyc(1'b1, 1'b1, 32'hBFC0_0100, 1'b0, 32'h0, 32'hBFC0_0000, 1'b1, 1'b1, "st1");
    cyc(1'b1, 1'b0, 32'h0,         1'b0, 32'h0, 32'hBFC0_0000, 1'b1, 1'b1, "st2");
    cyc(1'b1, 1'b0, 32'h0,         1'b0, 32'h0, 32'hBFC0_0000, 1'b1, 1'b1, "st3");
    cyc(1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 32'hBFC0_0100, 1'b1, 1'b0, "rel");
    cyc(1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 32'hBFC0_0104, 1'b1, 1'b0, "seq");

    // Latest branch during one stall wins.
    cyc(1'b1, 1'b1, 32'hBFC0_0100, 1'b0, 32'h0, 32'hBFC0_0104, 1'b1, 1'b1, "lw1");
    cyc(1'b1, 1'b1, 32'hBFC0_0200, 1'b0, 32'h0, 32'hBFC0_0104, 1'b1, 1'b1, "lw2");
    cyc(1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 32'hBFC0_0200, 1'b1, 1'b0, "lw3");

    // Flush beats stall and branch in the same cycle.
    cyc(1'b1, 1'b1, 32'hBFC0_0100, 1'b1, 32'h8000_0180, 32'h8000_0180, 1'b1, 1'b0, "sim");
    cyc(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h8000_0184, 1'b1, 1'b0, "sim2");

    // Live branch beats a stored one on release.
    cyc(1'b1, 1'b1, 32'hBFC0_0100, 1'b0, 32'h0, 32'h8000_0184, 1'b1, 1'b1, "lv1");
    cyc(1'b0, 1'b1, 32'hBFC0_0300, 1'b0, 32'h0, 32'hBFC0_0300, 1'b1, 1'b0, "lv2");
    cyc(1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 32'hBFC0_0304, 1'b1, 1'b0, "lv3");

    // Misaligned targets are kept as given.
    cyc(1'b0, 1'b1, 32'hBFC0_0102, 1'b0, 32'h0, 32'hBFC0_0102, 1'b1, 1'b0, "ma1");
    cyc(1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 32'hBFC0_0106, 1'b1, 1'b0, "ma2");
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_0180, 32'h8000_0180, 1'b1, 1'b0, "ma3");

    // Asynchronous reset with a branch pending.
    cyc(1'b0, 1'b1, 32'hBFC0_0040, 1'b0, 32'h0, 32'hBFC0_0040, 1'b1, 1'b0, "ar1");
    cyc(1'b1, 1'b1, 32'hBFC0_0500, 1'b0, 32'h0, 32'hBFC0_0040, 1'b1, 1'b1, "ar2");
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst.pc",   pc, 32'hBFC0_0000);
    check_eq("arst.ce",   {31'd0, ce},   32'd0);
    check_eq("arst.pend", {31'd0, pend}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_0180, 32'hBFC0_0000, 1'b1, 1'b0, "fce0");
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0,         32'hBFC0_0004, 1'b1, 1'b0, "lost");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
